// File: rtl/ex_mac_unit.sv
// ex_mac_unit: multi-cycle multiply / multiply-accumulate engine for the EX stage.
// Executes MULT, MULTU, MADD, MADDU, MSUB and MSUBU. The product is built by
// shift-and-add, BITS_PER_CYCLE multiplier bits per cycle, while EX is held
// through stallreq_o. Accumulating ops hand the product to EX/MEM through
// hilo_temp_o/cnt_o. The register loops it back via hilo_temp_i/cnt_i, and the
// final HI/LO sum is formed from the looped-back value.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   aluop_i           EX ALU op code
//   reg1_i, reg2_i    multiplicand (rs), multiplier (rt)
//   hi_i, lo_i        forwarded current HI/LO
//   hilo_temp_i       partial result looped back from EX/MEM
//   cnt_i             phase count looped back from EX/MEM
//   stall_i           pipeline stall vector (bit 3: EX/MEM held)
//   flush_i           pipeline flush
//   stallreq_o        request to hold EX
//   whilo_o           HI/LO write enable
//   hi_o, lo_o        HI/LO result
//   hilo_temp_o       partial result to EX/MEM
//   cnt_o             phase count: 00 none, 01 product ready, 10 accumulate done
module ex_mac_unit #(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o
);

  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;

  localparam int unsigned N         = 32 / BITS_PER_CYCLE;
  localparam int unsigned STEPW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE, S_ACC} state_t;

  state_t           r_state;
  logic [STEPW-1:0] r_step;
  logic [63:0]      r_mcand;
  logic [31:0]      r_mplier;
  logic [63:0]      r_acc;
  logic             r_sign;
  logic             r_mac;
  logic             r_sub;

  logic        w_is_op;
  logic        w_is_signed;
  logic        w_is_mac;
  logic        w_is_sub;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [63:0] w_pp;
  logic [63:0] w_sum;
  logic [63:0] w_prod;
  logic [63:0] w_store;
  logic [63:0] w_loop_sum;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall_i[5:4], stall_i[2:0]};

  always_comb begin
    w_is_op     = 1'b1;
    w_is_signed = 1'b0;
    w_is_mac    = 1'b0;
    w_is_sub    = 1'b0;
    case (aluop_i)
      EXE_MULT_OP:  w_is_signed = 1'b1;
      EXE_MULTU_OP: ;
      EXE_MADD_OP:  begin w_is_signed = 1'b1; w_is_mac = 1'b1; end
      EXE_MADDU_OP: w_is_mac = 1'b1;
      EXE_MSUB_OP:  begin w_is_signed = 1'b1; w_is_mac = 1'b1; w_is_sub = 1'b1; end
      EXE_MSUBU_OP: begin w_is_mac = 1'b1; w_is_sub = 1'b1; end
      default:      w_is_op = 1'b0;
    endcase
  end

  // 32-bit negation of 0x80000000 yields 0x80000000, i.e. 2^31 as a magnitude.
  assign w_mag1 = (w_is_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
  assign w_mag2 = (w_is_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

  // Partial product of the multiplicand and the low multiplier digit.
  always_comb begin
    w_pp = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
    end
  end

  assign w_sum      = r_acc + w_pp;
  assign w_prod     = r_sign ? (64'd0 - w_sum) : w_sum;
  assign w_store    = r_sub ? (64'd0 - w_prod) : w_prod;
  assign w_loop_sum = hilo_temp_i + {hi_i, lo_i};

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_sign   <= 1'b0;
      r_mac    <= 1'b0;
      r_sub    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_op && cnt_i == 2'b00) begin
            r_mcand  <= {32'd0, w_mag1};
            r_mplier <= w_mag2;
            r_acc    <= '0;
            r_step   <= '0;
            r_sign   <= w_is_signed & (reg1_i[31] ^ reg2_i[31]);
            r_mac    <= w_is_mac;
            r_sub    <= w_is_sub;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_step   <= r_step + STEPW'(1);
          if (r_step == LAST_STEP) begin
            // Last digit: fold in sign correction and MSUB negation at once.
            r_acc   <= w_store;
            r_state <= S_DONE;
          end else begin
            r_acc <= w_sum;
          end
        end
        S_DONE: begin
          if (r_mac)            r_state <= S_ACC;
          else if (!stall_i[3]) r_state <= S_IDLE;
        end
        S_ACC: begin
          if (!stall_i[3]) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o  = 1'b0;
    whilo_o     = 1'b0;
    hi_o        = '0;
    lo_o        = '0;
    hilo_temp_o = '0;
    cnt_o       = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_is_op && cnt_i == 2'b00) begin
          stallreq_o = 1'b1;
        end else if (w_is_op && w_is_mac && cnt_i == 2'b10) begin
          // Accumulate already finished: replay the looped-back sum, no restart.
          {hi_o, lo_o} = w_loop_sum;
          whilo_o      = 1'b1;
          hilo_temp_o  = hilo_temp_i;
          cnt_o        = 2'b10;
        end
      end
      S_MUL: stallreq_o = 1'b1;
      S_DONE: begin
        if (r_mac) begin
          hilo_temp_o = r_acc;
          cnt_o       = 2'b01;
          stallreq_o  = 1'b1;
        end else begin
          {hi_o, lo_o} = r_acc;
          whilo_o      = 1'b1;
        end
      end
      S_ACC: begin
        {hi_o, lo_o} = w_loop_sum;
        whilo_o      = 1'b1;
        hilo_temp_o  = r_acc;
        cnt_o        = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ex_mac_unit.sv
// Directed bench for ex_mac_unit with a behavioural EX/MEM loopback register.
module tb_ex_mac_unit;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_MADD  = 8'b10100110;
  localparam logic [7:0] OP_MSUB  = 8'b10101010;
  localparam logic [7:0] OP_MSUBU = 8'b10101011;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = '0;
  logic [31:0] reg1_i = '0, reg2_i = '0, hi_i = '0, lo_i = '0;
  logic [63:0] hilo_temp_i = '0;
  logic [1:0]  cnt_i = '0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        stallreq_o, whilo_o;
  logic [31:0] hi_o, lo_o;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  logic        ovr_en = 1'b0;
  logic [63:0] ovr_hilo = '0;
  logic [1:0]  ovr_cnt = '0;

  int unsigned total = 0;
  int unsigned bad = 0;

  ex_mac_unit #(.BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .hi_i(hi_i), .lo_i(lo_i), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .stall_i(stall_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .hilo_temp_o(hilo_temp_o),
    .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // EX/MEM register model: passes hilo_temp/cnt back while EX is stalled.
  always @(posedge clk) begin
    if (ovr_en) begin
      hilo_temp_i <= ovr_hilo;
      cnt_i       <= ovr_cnt;
    end else if (rst || flush_i) begin
      hilo_temp_i <= '0;
      cnt_i       <= '0;
    end else if (stallreq_o) begin
      hilo_temp_i <= hilo_temp_o;
      cnt_i       <= cnt_o;
    end else if (!stall_i[3]) begin
      hilo_temp_i <= '0;
      cnt_i       <= '0;
    end
  end

  function automatic logic [131:0] outs();
    return {stallreq_o, whilo_o, hi_o, lo_o, hilo_temp_o, cnt_o};
  endfunction

  function automatic logic [131:0] mk(input logic sr, input logic wh, input logic [31:0] h,
                                      input logic [31:0] l, input logic [63:0] t,
                                      input logic [1:0] c);
    return {sr, wh, h, l, t, c};
  endfunction

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an op and step through cycles 0..N, requiring stall and no write throughout.
  task automatic launch(input logic [7:0] op, input logic [7:0] swap, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                        input string tag);
    logic ok;
    tick();
    aluop_i = op; reg1_i = a; reg2_i = b; hi_i = h; lo_i = l; stall_i = '0;
    #1;
    ok = 1'b1;
    for (int i = 0; i <= N; i++) begin
      if (i > 0) begin
        tick();
        if (i == 5) aluop_i = swap;
        #1;
      end
      if (stallreq_o !== 1'b1 || whilo_o !== 1'b0) ok = 1'b0;
    end
    chk(tag, {131'd0, ok}, 132'd1);
  endtask

  task automatic idle_check(input string tag);
    tick();
    aluop_i = OP_NOP; stall_i = '0;
    #1;
    chk(tag, outs(), '0);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset", outs(), '0);

    // MULT -1 x 2
    launch(OP_MULT, OP_MULT, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, "mult_busy");
    tick(); #1;
    chk("mult", outs(), mk(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'h0, 2'b00));
    idle_check("mult_idle");

    // MULTU same operands
    launch(OP_MULTU, OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, "multu_busy");
    tick(); #1;
    chk("multu", outs(), mk(1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFE, 64'h0, 2'b00));
    idle_check("multu_idle");

    // -2^31 x -2^31 with EX/MEM held for one extra cycle
    launch(OP_MULT, OP_MULT, 32'h80000000, 32'h80000000, 32'h0, 32'h0, "min_busy");
    tick(); stall_i = 6'b001000; #1;
    chk("min_sq", outs(), mk(1'b0, 1'b1, 32'h40000000, 32'h0, 64'h0, 2'b00));
    tick(); stall_i = '0; #1;
    chk("min_sq_hold", outs(), mk(1'b0, 1'b1, 32'h40000000, 32'h0, 64'h0, 2'b00));
    idle_check("min_idle");

    // MADD 3 x 4 onto 0x10
    launch(OP_MADD, OP_MADD, 32'd3, 32'd4, 32'h0, 32'h10, "madd_busy");
    tick(); #1;
    chk("madd_done", outs(), mk(1'b1, 1'b0, 32'h0, 32'h0, 64'hC, 2'b01));
    tick(); #1;
    chk("madd_acc", outs(), mk(1'b0, 1'b1, 32'h0, 32'h1C, 64'hC, 2'b10));
    idle_check("madd_idle");

    // MSUBU 3 x 5 from 0x10, aluop changed mid-op, ACC held 3 extra cycles
    launch(OP_MSUBU, OP_MULTU, 32'd3, 32'd5, 32'h0, 32'h10, "msubu_busy");
    tick(); #1;
    chk("msubu_done", outs(), mk(1'b1, 1'b0, 32'h0, 32'h0, 64'hFFFFFFFF_FFFFFFF1, 2'b01));
    tick(); stall_i = 6'b001000; #1;
    chk("msubu_acc", outs(), mk(1'b0, 1'b1, 32'h0, 32'h1, 64'hFFFFFFFF_FFFFFFF1, 2'b10));
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) stall_i = '0;
      #1;
      chk("msubu_hold", outs(), mk(1'b0, 1'b1, 32'h0, 32'h1, 64'hFFFFFFFF_FFFFFFF1, 2'b10));
    end
    idle_check("msubu_idle");

    // Signed MADD -3 x 4 onto 0x10
    launch(OP_MADD, OP_MADD, 32'hFFFFFFFD, 32'd4, 32'h0, 32'h10, "madds_busy");
    tick(); #1;
    chk("madds_done", outs(), mk(1'b1, 1'b0, 32'h0, 32'h0, 64'hFFFFFFFF_FFFFFFF4, 2'b01));
    tick(); #1;
    chk("madds_acc", outs(), mk(1'b0, 1'b1, 32'h0, 32'h4, 64'hFFFFFFFF_FFFFFFF4, 2'b10));
    idle_check("madds_idle");

    // MSUB of 0 x -7 leaves HI/LO unchanged
    launch(OP_MSUB, OP_MSUB, 32'h0, 32'hFFFFFFF9, 32'h12345678, 32'h9ABCDEF0, "msub0_busy");
    tick(); #1;
    chk("msub0_done", outs(), mk(1'b1, 1'b0, 32'h0, 32'h0, 64'h0, 2'b01));
    tick(); #1;
    chk("msub0_acc", outs(), mk(1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 64'h0, 2'b10));
    idle_check("msub0_idle");

    // Flush in MUL cycle 5
    tick(); aluop_i = OP_MULT; reg1_i = 32'd7; reg2_i = 32'd9; hi_i = '0; lo_i = '0; #1;
    repeat (5) tick();
    flush_i = 1'b1; aluop_i = OP_NOP; #1;
    tick(); flush_i = 1'b0; #1;
    chk("flush_zero", outs(), '0);
    launch(OP_MULT, OP_MULT, 32'd2, 32'd3, 32'h0, 32'h0, "post_flush_busy");
    tick(); #1;
    chk("post_flush", outs(), mk(1'b0, 1'b1, 32'h0, 32'h6, 64'h0, 2'b00));
    idle_check("post_flush_idle");

    // Reset during ACC
    launch(OP_MADD, OP_MADD, 32'd1, 32'd1, 32'h0, 32'h0, "rstacc_busy");
    tick(); #1;
    chk("rstacc_done", outs(), mk(1'b1, 1'b0, 32'h0, 32'h0, 64'h1, 2'b01));
    tick(); rst = 1'b1; aluop_i = OP_NOP; #1;
    chk("rstacc_acc", outs(), mk(1'b0, 1'b1, 32'h0, 32'h1, 64'h1, 2'b10));
    tick(); rst = 1'b0; #1;
    chk("rst_zero", outs(), '0);
    launch(OP_MULTU, OP_MULTU, 32'd2, 32'd3, 32'h0, 32'h0, "post_rst_busy");
    tick(); #1;
    chk("post_rst", outs(), mk(1'b0, 1'b1, 32'h0, 32'h6, 64'h0, 2'b00));
    idle_check("post_rst_idle");

    // cnt_i==10 in IDLE: replay sum, no restart
    tick(); ovr_en = 1'b1; ovr_hilo = 64'h5; ovr_cnt = 2'b10; #1;
    tick(); aluop_i = OP_MADD; hi_i = 32'h0; lo_i = 32'h10; #1;
    chk("cnt10", outs(), mk(1'b0, 1'b1, 32'h0, 32'h15, 64'h5, 2'b10));
    tick(); #1;
    chk("cnt10_norestart", outs(), mk(1'b0, 1'b1, 32'h0, 32'h15, 64'h5, 2'b10));
    ovr_en = 1'b0;
    idle_check("cnt10_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mac_unit.md
Name: ex_mac_unit

Overview:
- Multi-cycle multiply and multiply-accumulate engine in the EX stage. Handles MULT, MULTU, MADD, MADDU, MSUB and MSUBU.
- Computes the 64-bit product iteratively and holds EX with a stall request until the result is ready.
- It is the producing/consuming end of the hilo_temp/cnt loopback. It emits a partial result and a phase count to the EX/MEM register. While EX is stalled, that register returns both values one cycle later, and this unit uses them to finish the accumulate phase.

Parameters:
- BITS_PER_CYCLE, 2, multiplier bits consumed per MUL cycle. Legal values: 1, 2, 4, 8. N = 32/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high (`RstEnable)
- aluop_i  in  8  EX ALU op; unit acts on `EXE_MULT_OP, `EXE_MULTU_OP, `EXE_MADD_OP, `EXE_MADDU_OP, `EXE_MSUB_OP, `EXE_MSUBU_OP
- reg1_i  in  32  multiplicand (rs)
- reg2_i  in  32  multiplier (rt)
- hi_i  in  32  forwarded current HI
- lo_i  in  32  forwarded current LO
- hilo_temp_i  in  64  partial result looped back from EX/MEM
- cnt_i  in  2  phase count looped back from EX/MEM
- stall_i  in  6  pipeline stall vector; bit 3 = EX/MEM held
- flush_i  in  1  pipeline flush
- stallreq_o  out  1  request to hold EX
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI result
- lo_o  out  32  LO result
- hilo_temp_o  out  64  partial result to EX/MEM
- cnt_o  out  2  phase count to EX/MEM: 00 none, 01 product ready, 10 accumulate done

Behaviour:

Registers and reset
- Internal registers: state, step counter, multiplicand magnitude (64-bit, shifted), multiplier magnitude (shifted), accumulator (64-bit), result sign, op class.
- rst or flush_i, on the clock edge: state goes to IDLE and all internal registers clear.
- With state IDLE and no op present, every output is 0.

IDLE
- Op is a MAC op and cnt_i==00: load the magnitudes of reg1_i and reg2_i. Signed ops use the two's-complement magnitude; 0x80000000 maps to 2^31. sign = reg1[31]^reg2[31] for signed ops, 0 for unsigned.
- In that cycle: stallreq_o=1. Next state MUL.

MUL, cycles 1..N
- Each cycle: add (multiplicand × low BITS_PER_CYCLE bits of multiplier) to the accumulator. Then shift the multiplicand left and the multiplier right by BITS_PER_CYCLE.
- stallreq_o=1.
- After cycle N: product P = sign ? -acc : acc (64-bit, wraps).
- For MSUB/MSUBU, the stored value is -P. This negation is applied after the sign correction.
- Next state DONE.

DONE, MULT/MULTU
- hi_o/lo_o = P[63:32]/P[31:0], whilo_o=1, stallreq_o=0.
- Stay in DONE with outputs held while stall_i[3]==1. Go to IDLE on the first cycle with stall_i[3]==0.

DONE, MADD/MSUB family
- hilo_temp_o = stored value, cnt_o=01, stallreq_o=1, whilo_o=0.
- Next state ACC.

ACC
- Entered with cnt_i==01 and hilo_temp_i equal to the stored value.
- {hi_o,lo_o} = hilo_temp_i + {hi_i,lo_i} (64-bit, wraps), whilo_o=1, stallreq_o=0, cnt_o=10.
- hilo_temp_o keeps the stored value, so a repeated loopback during an external stall recomputes the same sum.
- Leave to IDLE on the first cycle with stall_i[3]==0.

Latency and boundaries
- EX occupancy: MULT = N+2 cycles; MADD/MSUB = N+3 cycles. With the default parameter these are 18 and 19.
- cnt_i==10 in IDLE with a MAC op means the accumulate already completed. Do not restart. Output the looped-back result path as in ACC.
- aluop_i changing mid-operation is ignored; the latched op class is used.
- rst or flush in any state aborts on that edge. The next cycle's outputs are 0 and no HI/LO write is issued.
- Operand corner cases:
  - -2^31 × -2^31 = +2^62.
  - 0 × anything = 0.
  - MSUB of 0 leaves HI/LO unchanged.

Test Plan:
- MULT reg1=0xFFFFFFFF, reg2=0x2 -> 17 cycles after start: whilo=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE, stallreq low only in that cycle.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- MADD hi/lo=0/0x10, 3×4, with the EX/MEM loopback model -> DONE: cnt_o=01, hilo_temp_o=0xC. ACC: lo=0x1C, hi=0, cnt_o=10.
- MSUBU hi/lo=0/0x10, 3×5 -> hilo_temp_o=0xFFFFFFFF_FFFFFFF1. Result hi=0, lo=0x1. Hold stall_i[3]=1 for 3 extra cycles -> same result each cycle.
- flush_i asserted in MUL cycle 5, and separately rst in ACC -> next cycle all outputs 0. A following MULT 2×3 gives lo=6 with full latency.
